// File: rtl/uart_receive_engine_if.sv
// Host-side bundle for the UART receiver: serial line, frame configuration
// and the received-byte handshake with its status flags.
interface uart_receive_engine_if;
    logic        rx;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic [18:0] baud_out;
    logic        read;
    logic [7:0]  rx_data;
    logic        RxRdy;
    logic        perr;
    logic        ferr;
    logic        ovf;

    modport master (
        output rx, eight, pen, ohel, baud_out, read,
        input  rx_data, RxRdy, perr, ferr, ovf
    );

    modport slave (
        input  rx, eight, pen, ohel, baud_out, read,
        output rx_data, RxRdy, perr, ferr, ovf
    );
endinterface

// File: rtl/uart_receive_engine.sv
// Asynchronous serial receiver: 7/8 data bits, optional odd/even parity, one
// stop bit; each byte is presented with ready/read handshake and error flags.
module uart_receive_engine (
    input  logic                 clk,
    input  logic                 reset,
    uart_receive_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, WAIT_HI} state_t;

    state_t      state_q;
    logic        rx_meta_q;
    logic        rx_s_q;
    logic [18:0] cnt_q;
    logic [3:0]  idx_q;
    logic [9:1]  frame_q;
    logic [7:0]  rx_data_q;
    logic        rx_rdy_q;
    logic        perr_q;
    logic        ferr_q;
    logic        ovf_q;

    logic [3:0]  last_idx;
    logic [7:0]  data_d;
    logic        par_bit;
    logic        par_exp;
    logic        perr_d;
    logic        half_bit;
    logic        full_bit;
    logic        data_sample;
    logic        complete;

    // Frame index 0 is the start bit; the stop bit is always index last_idx.
    always_comb begin
        last_idx    = 4'd8 + {3'd0, bus.eight} + {3'd0, bus.pen};
        data_d      = {bus.eight & frame_q[8], frame_q[7:1]};
        par_bit     = bus.eight ? frame_q[9] : frame_q[8];
        par_exp     = (^data_d) ^ bus.ohel;
        perr_d      = bus.pen & (par_bit != par_exp);
        half_bit    = (cnt_q == {1'b0, bus.baud_out[18:1]});
        full_bit    = (cnt_q == bus.baud_out);
        data_sample = (state_q == DATA) && full_bit;
        complete    = data_sample && (idx_q == last_idx);
    end

    generate
        for (genvar gi = 1; gi <= 9; gi++) begin : g_frame_bit
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    frame_q[gi] <= 1'b0;
                end else if (data_sample && idx_q == 4'(gi)) begin
                    frame_q[gi] <= rx_s_q;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            rx_data_q <= '0;
            rx_rdy_q  <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) state_q <= START;
                end
                START: begin
                    if (half_bit) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DATA;
                            idx_q   <= 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 19'd1;
                    end
                end
                DATA: begin
                    if (full_bit) begin
                        cnt_q <= '0;
                        idx_q <= idx_q + 4'd1;
                        if (complete) state_q <= rx_s_q ? IDLE : WAIT_HI;
                    end else begin
                        cnt_q <= cnt_q + 19'd1;
                    end
                end
                WAIT_HI: begin
                    // A held-low line must rise before another start is accepted.
                    cnt_q <= '0;
                    if (rx_s_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // Completion has priority over a coincident read.
            if (complete) begin
                rx_data_q <= data_d;
                rx_rdy_q  <= 1'b1;
                perr_q    <= perr_d;
                ferr_q    <= ~rx_s_q;
                ovf_q     <= ~bus.read & (ovf_q | rx_rdy_q);
            end else if (bus.read) begin
                rx_rdy_q <= 1'b0;
                perr_q   <= 1'b0;
                ferr_q   <= 1'b0;
                ovf_q    <= 1'b0;
            end
        end
    end

    assign bus.rx_data = rx_data_q;
    assign bus.RxRdy   = rx_rdy_q;
    assign bus.perr    = perr_q;
    assign bus.ferr    = ferr_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: doc/uart_receive_engine.md
# uart_receive_engine

Serial receive stage paired with the UART transmit engine. It recovers 7- or 8-bit asynchronous frames from the `rx` line, checks parity and the stop bit, and presents each byte to the host on a ready/read handshake. Frame format and bit period use the same `eight`/`pen`/`ohel`/`baud_out` settings that drive the transmitter.

## Interface
- No parameters; all configuration is through ports.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `rx` in 1: serial line, idle high, asynchronous to `clk`.
- `eight` in 1: 1 = 8 data bits, 0 = 7 data bits.
- `pen` in 1: parity enable.
- `ohel` in 1: 1 = odd parity, 0 = even parity; ignored when `pen`=0.
- `baud_out` in 19: bit period minus 1, in clocks.
- `read` in 1: one-cycle pulse; host consumed the byte.
- `rx_data` out 8: last received byte, LSB = first data bit; bit 7 = 0 when `eight`=0.
- `RxRdy` out 1: byte available.
- `perr` out 1: parity error on the last frame.
- `ferr` out 1: framing error (stop bit sampled 0).
- `ovf` out 1: a frame completed while `RxRdy` was already 1.

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1, giving `rx_s`. All decisions use `rx_s`.
- Samples per frame: N = 1 (start) + 7 + `eight` + `pen` + 1 (stop), giving 9 to 11.
- Bit-time counter is 19 bits. It clears on any state change and on each sample.
- FSM states:
  - IDLE: if `rx_s`=0, go to START and clear the counter.
  - START: when counter == `baud_out`>>1 (half bit), sample `rx_s`. If it is 1, this is a false start: go to IDLE. If it is 0, go to DATA with bit index 1.
  - DATA: when counter == `baud_out` (full bit), sample `rx_s` into the frame register at the current index and increment the index. After the stop sample (index N-1), complete the frame. If the stop bit is 1, go to IDLE. If it is 0, go to WAIT_HI.
  - WAIT_HI: stay until `rx_s`=1, then go to IDLE. A held-low or break line therefore yields one frame, not a stream.
- Bit mapping after start:
  - Data bits arrive LSB first.
  - The parity bit follows if `pen`=1.
  - The stop bit is last.
- Parity: P = XOR of the received data bits (7 or 8).
  - Even (`ohel`=0): expected bit = P.
  - Odd: expected bit = ~P.
  - `perr` = `pen` & (received parity ≠ expected).
- On frame completion, in one cycle:
  - `rx_data` is loaded.
  - `RxRdy` goes to 1.
  - `perr` and `ferr` are loaded with this frame's results.
  - `ovf` is set to 1 if `RxRdy` was 1 and `read` is 0.
- `read` clears `RxRdy`, `perr`, `ferr` and `ovf`. `rx_data` holds its value.
- `read` in the same cycle as frame completion: completion wins. `RxRdy`=1, the flags reflect the new frame, and `ovf`=0.
- `ovf` is sticky until `read`. On overflow, `rx_data` is overwritten with the newer byte.
- Configuration inputs must be stable while not in IDLE; changing them mid-frame is undefined.
- `reset` at any time, including mid-frame, immediately forces the reset values and state IDLE.

## Timing
- Reset values:
  - `rx_data`=0x00.
  - `RxRdy`=0, `perr`=0, `ferr`=0, `ovf`=0.
  - Synchronizer flops = 1, state = IDLE.
- Input latency: `rx` falling edge to `rx_s` low is 2 clocks.
- Start sample: (`baud_out`>>1)+1 clocks after entering START.
- Subsequent samples: every `baud_out`+1 clocks.
- Outputs update on the clock after the stop sample.
- Example: `baud_out`=15, 8N1. The start sample is 8 clocks after START, then samples come every 16 clocks. `RxRdy` rises about 2+8+9·16+1 = 155 clocks after the `rx` falling edge.
- Back-to-back frames are supported: the next start edge can be detected one clock after returning to IDLE.

## Test plan
- 8N1 (`eight`=1, `pen`=0, `baud_out`=15), send 0xA5 → `rx_data`=0xA5, `RxRdy`=1, `perr`=`ferr`=`ovf`=0. Then pulse `read` → `RxRdy`=0 and `rx_data` stays 0xA5.
- 7E1 (`eight`=0, `pen`=1, `ohel`=0), send 0x41 with parity 0 → `rx_data`=0x41, `perr`=0. Resend with parity 1 → `perr`=1.
- 8O1 (`ohel`=1), send 0x03 with parity 1 → `perr`=0. Send 0x07 with parity 1 → `perr`=1.
- Framing: 8N1 0x5A with stop bit 0, line held low for 40 bit-times → exactly one `RxRdy`, with `ferr`=1. No further frame until the line returns high and a new start arrives.
- False start: a 4-clock low glitch with `baud_out`=15 → state returns to IDLE and `RxRdy` stays 0. A valid 0x33 sent immediately after is received correctly.
- Overflow and resets:
  - Two frames 0x11 then 0x22 with no `read` → `rx_data`=0x22, `ovf`=1. A `read` clears all flags.
  - `read` coincident with completion → `ovf`=0.
  - `reset` asserted mid-frame → all outputs return to 0 and the next full frame is received correctly.
